// File: rtl/instruction_loader.sv
// Packs UART bytes (MSB first) into 32-bit instructions and writes them to
// consecutive word addresses of instruction memory until HALT or memory full.
module instruction_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 NB_ADDR   = 10,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_imem_wr_en,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0] o_imem_wr_data,
  output logic               o_busy,
  output logic               o_load_done,
  output logic               o_overflow,
  output logic [NB_ADDR-2:0] o_word_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = {{(NB_ADDR-2){1'b1}}, 2'b00};
  localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(4);
  localparam logic [NB_ADDR-2:0] CNT_ONE   = (NB_ADDR-1)'(1);

  state_t             r_state;
  logic [NB_DATA-1:0] r_word;
  logic [1:0]         r_byte_cnt;
  logic               r_wr_en;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_DATA-1:0] r_wr_data;
  logic               r_busy;
  logic               r_load_done;
  logic               r_overflow;
  logic [NB_ADDR-2:0] r_word_count;

  logic [NB_DATA-1:0] w_next_word;

  assign w_next_word = {r_word[NB_DATA-NB_BYTE-1:0], i_rx_data};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_word       <= '0;
      r_byte_cnt   <= 2'd0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_load_done  <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        // A new load may begin from rest or after a finished load.
        IDLE, DONE: begin
          r_wr_en <= 1'b0;
          if (i_start) begin
            r_state      <= RECEIVE;
            r_byte_cnt   <= 2'd0;
            r_addr       <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_load_done  <= 1'b0;
            r_busy       <= 1'b1;
          end else begin
            r_state <= r_state;
          end
        end
        RECEIVE: begin
          if (i_rx_valid) begin
            r_word     <= w_next_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state   <= WRITE;
              r_wr_en   <= 1'b1;
              r_wr_data <= w_next_word;
            end else begin
              r_state <= RECEIVE;
            end
          end else begin
            r_state <= RECEIVE;
          end
        end
        // HALT wins over the full-memory check when both hit on the last slot.
        WRITE: begin
          r_wr_en      <= 1'b0;
          r_word_count <= r_word_count + CNT_ONE;
          if (r_wr_data == HALT_WORD) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_load_done <= 1'b1;
          end else if (r_addr == LAST_ADDR) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_load_done <= 1'b1;
            r_overflow  <= 1'b1;
          end else begin
            r_state <= RECEIVE;
            r_addr  <= r_addr + ADDR_STEP;
            if (i_rx_valid) begin
              r_word     <= w_next_word;
              r_byte_cnt <= 2'd1;
            end else begin
              r_byte_cnt <= 2'd0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_wr_en   = r_wr_en;
  assign o_imem_addr    = r_addr;
  assign o_imem_wr_data = r_wr_data;
  assign o_busy         = r_busy;
  assign o_load_done    = r_load_done;
  assign o_overflow     = r_overflow;
  assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: cycle table, reset corner cases,
// memory-full load and random loads against a byte-stream reference model.
module tb_instruction_loader;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_imem_wr_en;
  logic [9:0]  o_imem_addr;
  logic [31:0] o_imem_wr_data;
  logic        o_busy;
  logic        o_load_done;
  logic        o_overflow;
  logic [8:0]  o_word_count;

  instruction_loader #(
    .NB_DATA(32), .NB_BYTE(8), .NB_ADDR(10), .HALT_WORD(32'hFFFFFFFF)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_imem_wr_en(o_imem_wr_en), .o_imem_addr(o_imem_addr),
    .o_imem_wr_data(o_imem_wr_data), .o_busy(o_busy),
    .o_load_done(o_load_done), .o_overflow(o_overflow),
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        wr_en;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [8:0]  cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  sent_q[$];
  logic [41:0] exp_q[$];
  logic        sb_en = 1'b0;
  logic        prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every write must match the next expected {addr, data}.
  always @(negedge i_clk) begin
    if (sb_en && o_imem_wr_en) begin
      chk("wr_pulse_width", 32'(prev_wr), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                 o_imem_addr, o_imem_wr_data);
      end else begin
        chk("wr_addr", 32'(o_imem_addr), 32'(exp_q[0][41:32]));
        chk("wr_data", o_imem_wr_data, exp_q[0][31:0]);
        void'(exp_q.pop_front());
      end
    end
    prev_wr <= o_imem_wr_en;
  end

  function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic we, logic [9:0] a,
                              logic [31:0] wd, logic b, logic dn, logic ov, logic [8:0] c);
    vec_t r;
    r.start = s; r.valid = v; r.data = d; r.wr_en = we; r.addr = a;
    r.wdata = wd; r.busy = b; r.done = dn; r.ovf = ov; r.cnt = c;
    return r;
  endfunction

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_reset_n  = 1'b0;
    #3;
    i_reset_n  = 1'b1;
    cycle();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(o_imem_wr_en), 32'd0);
    chk({tag, "_addr"},  32'(o_imem_addr), 32'd0);
    chk({tag, "_data"},  o_imem_wr_data, 32'd0);
    chk({tag, "_busy"},  32'(o_busy), 32'd0);
    chk({tag, "_done"},  32'(o_load_done), 32'd0);
    chk({tag, "_ovf"},   32'(o_overflow), 32'd0);
    chk({tag, "_count"}, 32'(o_word_count), 32'd0);
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) cycle();
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    cycle();
    i_rx_valid = 1'b0;
  endtask

  // Reference model: bytes group into words MSB first; the load stops at HALT
  // (which is still written) or after 256 words; later bytes are ignored.
  task automatic prepare_expected(output int nwords, output bit ovf);
    logic [31:0] w;
    bit stop;
    stop = 1'b0;
    nwords = 0;
    ovf = 1'b0;
    exp_q.delete();
    for (int i = 0; i + 3 < sent_q.size() && !stop; i += 4) begin
      w = {sent_q[i], sent_q[i+1], sent_q[i+2], sent_q[i+3]};
      exp_q.push_back({10'(nwords * 4), w});
      nwords++;
      if (w == HALT) stop = 1'b1;
      else if (nwords == 256) begin
        stop = 1'b1;
        ovf = 1'b1;
      end
    end
  endtask

  task automatic run_load(input int max_gap, output int nwords, output bit ovf);
    prepare_expected(nwords, ovf);
    start_pulse();
    foreach (sent_q[i]) send_byte(sent_q[i], int'($urandom_range(0, max_gap)));
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!o_load_done && n < limit) begin
      cycle();
      n++;
    end
    chk("done_timeout", 32'(o_load_done), 32'd1);
  endtask

  task automatic push_word(input logic [31:0] w);
    sent_q.push_back(w[31:24]);
    sent_q.push_back(w[23:16]);
    sent_q.push_back(w[15:8]);
    sent_q.push_back(w[7:0]);
  endtask

  initial begin
    int nw;
    bit ov;
    logic [31:0] w;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_reset_n  = 1'b0;
    cycle();
    check_zero("reset");
    i_reset_n = 1'b1;
    cycle();

    // Three-word program with back-to-back bytes, bytes after HALT, then restart.
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h20, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h05, 1'b1, 10'h000, 32'h20010005, 1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h30, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h22, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h0F, 1'b1, 10'h004, 32'h3022000F, 1'b1, 1'b0, 1'b0, 9'd1));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd2));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd2));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd2));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd2));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 10'h008, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 9'd2));
    tbl.push_back(mk(1'b0, 1'b1, 8'h5A, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 9'd3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h11, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 9'd3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h22, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 9'd3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h33, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 9'd3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h44, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 9'd3));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h12, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h34, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h56, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h78, 1'b1, 10'h000, 32'h12345678, 1'b1, 1'b0, 1'b0, 9'd0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 9'd1));
    foreach (tbl[k]) begin
      i_start    = tbl[k].start;
      i_rx_valid = tbl[k].valid;
      i_rx_data  = tbl[k].data;
      cycle();
      chk($sformatf("tbl%0d_wr_en", k), 32'(o_imem_wr_en), 32'(tbl[k].wr_en));
      chk($sformatf("tbl%0d_busy", k),  32'(o_busy),       32'(tbl[k].busy));
      chk($sformatf("tbl%0d_done", k),  32'(o_load_done),  32'(tbl[k].done));
      chk($sformatf("tbl%0d_ovf", k),   32'(o_overflow),   32'(tbl[k].ovf));
      if (tbl[k].wr_en) begin
        chk($sformatf("tbl%0d_addr", k), 32'(o_imem_addr), 32'(tbl[k].addr));
        chk($sformatf("tbl%0d_data", k), o_imem_wr_data,   tbl[k].wdata);
      end else begin
        chk($sformatf("tbl%0d_count", k), 32'(o_word_count), 32'(tbl[k].cnt));
      end
    end
    i_start    = 1'b0;
    i_rx_valid = 1'b0;

    // Reset after two bytes must leave no residue in the next load.
    do_reset();
    sb_en = 1'b1;
    start_pulse();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    i_reset_n = 1'b0;
    #1;
    check_zero("rst_recv");
    #2;
    i_reset_n = 1'b1;
    cycle();
    sent_q.delete();
    push_word(32'h20010005);
    run_load(1, nw, ov);
    repeat (3) cycle();
    chk("rst_recv_pending", 32'(exp_q.size()), 32'd0);
    chk("rst_recv_count", 32'(o_word_count), 32'd1);
    chk("rst_recv_busy", 32'(o_busy), 32'd1);

    // Reset while the write strobe is high aborts it immediately.
    do_reset();
    sb_en = 1'b0;
    start_pulse();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    chk("abort_wr_before", 32'(o_imem_wr_en), 32'd1);
    i_reset_n = 1'b0;
    #1;
    check_zero("rst_write");
    #2;
    i_reset_n = 1'b1;
    cycle();
    check_zero("after_abort");

    // Fill all 256 words without HALT; trailing FF bytes must be ignored.
    do_reset();
    sb_en = 1'b1;
    sent_q.delete();
    for (int i = 0; i < 256; i++) push_word($urandom & 32'h7FFFFFFF);
    push_word(HALT);
    run_load(0, nw, ov);
    wait_done(20);
    repeat (2) cycle();
    chk("full_overflow", 32'(o_overflow), 32'd1);
    chk("full_model_ovf", 32'(ov), 32'd1);
    chk("full_busy", 32'(o_busy), 32'd0);
    chk("full_pending", 32'(exp_q.size()), 32'd0);

    // Random programs with random byte spacing and junk after HALT.
    for (int l = 0; l < 6; l++) begin
      sent_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
        w = $urandom;
        if (w == HALT) w = 32'h0;
        push_word(w);
      end
      push_word(HALT);
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) sent_q.push_back(8'($urandom));
      run_load(2, nw, ov);
      wait_done(20);
      repeat (2) cycle();
      chk($sformatf("rnd%0d_count", l), 32'(o_word_count), 32'(nw));
      chk($sformatf("rnd%0d_ovf", l), 32'(o_overflow), 32'(ov));
      chk($sformatf("rnd%0d_pending", l), 32'(exp_q.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
